// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/response controller driving an external combinational ALU, owning the flag register
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [1:0]  alu_functionals,
  output logic [2:0]  alu_logicfn,
  input  logic [31:0] alu_value,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_msb,
  input  logic        alu_overflow,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_taken,
  output logic        resp_err,
  output logic [3:0]  flags
);
  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d, flags_q, flags_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [31:0] x_q, x_d, y_q, y_d, data_q, data_d;
  logic [1:0]  fn_q, fn_d;
  logic [2:0]  lf_q, lf_d;
  logic        rv_q, rv_d, taken_q, taken_d, err_q, err_d;
  logic [31:0] sra_fill;
  logic        cond;
  // Sign fill OR-ed onto the logical right shift to form an arithmetic shift
  assign sra_fill = a_q[31] ? ((|b_q[31:5]) ? 32'hFFFFFFFF : ~(32'hFFFFFFFF >> b_q[4:0])) : 32'h0;
  // Branch condition against the flags held before the branch op
  assign cond = op_q == 4'd8  ? flags_q[0] :
                op_q == 4'd9  ? !flags_q[0] :
                op_q == 4'd10 ? flags_q[2] :
                op_q == 4'd11 ? flags_q[1] :
                op_q == 4'd12 ? flags_q[3] : 1'b0;
  assign req_ready       = state_q == IDLE && !rst;
  assign alu_x           = x_q;
  assign alu_y           = y_q;
  assign alu_functionals = fn_q;
  assign alu_logicfn     = lf_q;
  assign resp_valid      = rv_q;
  assign resp_data       = data_q;
  assign resp_taken      = taken_q;
  assign resp_err        = err_q;
  assign flags           = flags_q;
  // Next-state: accept, ALU passes (SUB negates b first, then adds), response hold
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    x_d      = x_q;
    y_d      = y_q;
    fn_d     = fn_q;
    lf_d     = lf_q;
    flags_d  = flags_q;
    rv_d     = rv_q;
    data_d   = data_q;
    taken_d  = taken_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = EXEC1;
        op_d    = req_op;
        a_d     = req_a;
        b_d     = req_b;
        if (!req_op[3]) begin
          x_d  = (req_op == 4'd1 || req_op == 4'd7) ? 32'h0 : req_a;
          y_d  = req_b;
          fn_d = req_op == 4'd0 ? 2'b00 : (req_op == 4'd1 || req_op == 4'd7) ? 2'b01 : 2'b10;
          lf_d = req_op == 4'd3 ? 3'b001 : req_op == 4'd4 ? 3'b010 :
                 (req_op == 4'd5 || req_op == 4'd6) ? 3'b011 : 3'b000;
        end
      end
      EXEC1: begin
        result_d = op_q[3] ? 32'h0 : op_q == 4'd6 ? (alu_value | sra_fill) : alu_value;
        if (op_q == 4'd0) flags_d = {alu_overflow, alu_msb, alu_carry, alu_zero};
        if (op_q == 4'd7) begin
          state_d = EXEC2;
          x_d     = a_q;
          y_d     = alu_value;
          fn_d    = 2'b00;
        end else state_d = DONE;
      end
      EXEC2: begin
        result_d = alu_value;
        flags_d  = {alu_overflow, alu_msb, alu_carry, alu_zero};
        state_d  = DONE;
      end
      DONE: if (!rv_q) begin
        rv_d    = 1'b1;
        data_d  = result_q;
        taken_d = cond;
        err_d   = op_q >= 4'd13;
      end else if (resp_ready) begin
        rv_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // State and registered outputs; reset discards any in-flight op and clears flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fn_q     <= '0;
      lf_q     <= '0;
      flags_q  <= '0;
      rv_q     <= 1'b0;
      data_q   <= '0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fn_q     <= fn_d;
      lf_q     <= lf_d;
      flags_q  <= flags_d;
      rv_q     <= rv_d;
      data_q   <= data_d;
      taken_q  <= taken_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed ops against an operation-level reference model
module tb_alu_sequencer;
  logic        clk, rst, req_valid, req_ready, resp_valid, resp_ready, resp_taken, resp_err;
  logic [3:0]  req_op, flags;
  logic [31:0] req_a, req_b, alu_x, alu_y, alu_value, resp_data;
  logic [1:0]  alu_functionals;
  logic [2:0]  alu_logicfn;
  logic        alu_carry, alu_zero, alu_msb, alu_overflow;
  int          errors = 0, checks = 0, cycle_count = 0, acc_cyc = 0, exp_lat = 0;
  logic        pending = 0, prev_rv = 0, exp_taken, exp_err, last_taken, last_err;
  logic [31:0] exp_data, last_data;
  logic [3:0]  model_flags = 4'h0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .alu_x(alu_x), .alu_y(alu_y),
    .alu_functionals(alu_functionals), .alu_logicfn(alu_logicfn), .alu_value(alu_value),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_msb(alu_msb), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_taken(resp_taken), .resp_err(resp_err), .flags(flags)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Stand-in for the external combinational ALU; its msb flag reports the sign of x
  always_comb begin
    logic [31:0] yy, lg;
    logic [32:0] s;
    yy = alu_functionals[0] ? (~alu_y + 32'd1) : alu_y;
    s  = {1'b0, alu_x} + {1'b0, yy};
    lg = alu_logicfn == 3'b000 ? (alu_x & alu_y) :
         alu_logicfn == 3'b001 ? (alu_x ^ alu_y) :
         alu_logicfn == 3'b010 ? (alu_x << alu_y) :
         alu_logicfn == 3'b011 ? (alu_x >> alu_y) : 32'($signed(alu_x) >>> alu_y);
    alu_value    = alu_functionals[1] ? lg : s[31:0];
    alu_carry    = !alu_functionals[1] && s[32];
    alu_zero     = alu_value == 32'h0;
    alu_msb      = alu_x[31];
    alu_overflow = !alu_functionals[1] && (alu_x[31] == yy[31]) && (s[31] != alu_x[31]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic sovf(input logic [31:0] a, input logic [31:0] y);
    longint s;
    s = longint'($signed(a)) + longint'($signed(y));
    return s > 64'sd2147483647 || s < -64'sd2147483648;
  endfunction

  // Architectural result of one op from the flags held before it
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] fin, output logic [31:0] d, output logic t,
                                 output logic e, output logic [3:0] fo);
    logic [63:0] u;
    fo = fin; t = 0; e = 0; d = 0;
    case (op)
      4'd0: begin
        d = a + b;
        u = {32'h0, a} + {32'h0, b};
        fo = {sovf(a, b), a[31], u[32], d == 0};
      end
      4'd1: d = 32'h0 - b;
      4'd2: d = a & b;
      4'd3: d = a ^ b;
      4'd4: d = b >= 32 ? 32'h0 : a << b;
      4'd5: d = b >= 32 ? 32'h0 : a >> b;
      4'd6: d = b >= 32 ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
      4'd7: begin
        d = a - b;
        fo = {sovf(a, 32'h0 - b), a[31], b != 0 && a >= b, d == 0};
      end
      4'd8:  t = fin[0];
      4'd9:  t = !fin[0];
      4'd10: t = fin[2];
      4'd11: t = fin[1];
      4'd12: t = fin[3];
      default: e = 1;
    endcase
  endfunction

  // Per-cycle comparison against the model whenever outputs are meaningful
  always @(negedge clk) begin
    if (!rst) begin
      if (pending) begin
        chk("busy_ready", 32'(req_ready), 0);
        if (resp_valid && !prev_rv) chk("latency", cycle_count - acc_cyc, exp_lat);
        if (resp_valid) begin
          chk("resp_data", resp_data, exp_data);
          chk("resp_taken", 32'(resp_taken), 32'(exp_taken));
          chk("resp_err", 32'(resp_err), 32'(exp_err));
          chk("resp_flags", 32'(flags), 32'(model_flags));
        end
      end else begin
        chk("idle_valid", 32'(resp_valid), 0);
        chk("idle_ready", 32'(req_ready), 1);
        chk("idle_flags", 32'(flags), 32'(model_flags));
      end
      prev_rv = resp_valid;
    end
  end

  task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic spur);
    int n;
    logic [3:0] nf;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 1);
    req_op = op; req_a = a; req_b = b; req_valid = 1;
    @(posedge clk); #2;
    req_valid = 0;
    ref_op(op, a, b, model_flags, exp_data, exp_taken, exp_err, nf);
    model_flags = nf;
    exp_lat = op == 4'd7 ? 3 : 2;
    acc_cyc = cycle_count;
    pending = 1;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #2; n++; end
    if (!resp_valid) begin
      chk("resp_timeout", 32'(resp_valid), 1);
      pending = 0;
      return;
    end
    repeat (hold) begin
      req_valid = spur; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
      @(posedge clk); #2;
    end
    req_valid = 0; resp_ready = 1;
    last_data = resp_data; last_taken = resp_taken; last_err = resp_err;
    @(posedge clk); #2;
    resp_ready = 0;
    pending = 0;
  endtask

  initial begin
    rst = 1; req_valid = 0; resp_ready = 0; req_op = 0; req_a = 0; req_b = 0;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_data", resp_data, 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_alu_fn", {27'h0, alu_functionals, alu_logicfn}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    do_txn(4'd0, 32'hFFFFFFFF, 32'h1, 0, 0);
    chk("add_data", last_data, 32'h0);
    chk("add_flags", 32'(flags), 32'h7);
    do_txn(4'd7, 32'd5, 32'd5, 1, 0);
    chk("sub_data", last_data, 32'h0);
    chk("sub_flags", 32'(flags), 32'h3);
    do_txn(4'd8, 32'h0, 32'h0, 0, 0);
    chk("bz_taken", 32'(last_taken), 1);
    chk("bz_flags", 32'(flags), 32'h3);
    do_txn(4'd9, 32'h0, 32'h0, 0, 0);
    chk("bnz_taken", 32'(last_taken), 0);
    do_txn(4'd6, 32'h80000000, 32'd4, 0, 0);
    chk("sra_data", last_data, 32'hF8000000);
    do_txn(4'd5, 32'h80000000, 32'd4, 0, 0);
    chk("srl_data", last_data, 32'h08000000);
    do_txn(4'd6, 32'h80000000, 32'd40, 0, 0);
    chk("sra_big", last_data, 32'hFFFFFFFF);
    chk("shift_flags", 32'(flags), 32'h3);
    do_txn(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 3, 1);
    chk("xor_data", last_data, 32'hFF00FF00);
    do_txn(4'd14, 32'h1234, 32'h5678, 0, 0);
    chk("ill_err", 32'(last_err), 1);
    chk("ill_data", last_data, 0);
    chk("ill_flags", 32'(flags), 32'h3);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom_range(0, 2) == 0 ? $urandom : $urandom_range(0, 40);
      if ($urandom_range(0, 5) == 0) ra = rb;
      do_txn(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 3), 1'($urandom));
    end
    while (!req_ready) begin @(posedge clk); #2; end
    req_op = 4'd7; req_a = 32'd9; req_b = 32'd3; req_valid = 1;
    @(posedge clk); #2;
    req_valid = 0; pending = 1; exp_lat = 3; acc_cyc = cycle_count;
    @(posedge clk); #2;
    rst = 1; pending = 0; model_flags = 0;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 0);
    chk("mid_rst_flags", 32'(flags), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    @(posedge clk); #2;
    chk("mid_rst_alu_y", alu_y, 0);
    rst = 0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 1);
    repeat (3) @(posedge clk);
    #2;
    do_txn(4'd0, 32'h7FFFFFFF, 32'h1, 0, 0);
    chk("ovf_data", last_data, 32'h80000000);
    chk("ovf_flags", 32'(flags), 32'h8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
